// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains an 8-bit byte FIFO onto an 8N1 asynchronous serial line.
//   One byte is popped at a time. The FIFO has a registered read, so the byte
//   arrives the cycle after the pop strobe. The byte is then sent as one start
//   bit (0), eight data bits LSB first and one stop bit (1). Each bit lasts
//   CLKS_PER_BIT clocks.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous reset, active low (0 = in reset)
//   enable           1 = may start new frames; sampled only when a pop is decided
//   fifo_empty       upstream FIFO has no data
//   fifo_read_enable one-cycle pop strobe to the FIFO
//   fifo_data        FIFO read data, valid the cycle after fifo_read_enable
//   tx               serial line, idle high
//   busy             high from the cycle after the pop through the last stop-bit cycle
//   frames_sent      count of completed frames, wraps 16'hFFFF -> 0
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("fifo_uart_tx: the frame carries exactly 8 data bits, DATA_WIDTH must be 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_div
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [15:0]      frames_nxt;
    logic             tx_nxt, busy_nxt, rd_nxt;
    logic             bit_done;

    assign bit_done = (cnt == CNT_LAST);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            shift            <= '0;
            frames_sent      <= '0;
            tx               <= 1'b1;
            busy             <= 1'b0;
            fifo_read_enable <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            bit_idx          <= bit_idx_nxt;
            shift            <= shift_nxt;
            frames_sent      <= frames_nxt;
            tx               <= tx_nxt;
            busy             <= busy_nxt;
            fifo_read_enable <= rd_nxt;
        end
    end

    // Next-state logic. The IDLE cycle that carries the pop strobe moves to FETCH,
    // and FETCH captures the byte that the FIFO presents in that cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        frames_nxt  = frames_sent;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (fifo_read_enable) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                shift_nxt   = fifo_data[7:0];
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                state_nxt   = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_nxt   = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_nxt    = '0;
                    frames_nxt = frames_sent + 16'd1;
                    state_nxt  = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic. The outputs are registered from the next state, so every
    // output lines up with the state it belongs to and tx has no glitches.
    // The pop is decided on the edge that enters IDLE (or stays in IDLE). This
    // puts the strobe in the first IDLE cycle after a stop bit. The strobe blocks
    // itself for one cycle, so two pops never fall on consecutive cycles.
    always_comb begin
        busy_nxt = (state_nxt != S_IDLE);
        rd_nxt   = (state_nxt == S_IDLE) && !fifo_read_enable && enable && !fifo_empty;
        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
